// File: rtl/mobilenet_pw_group_prefetch_pkg.sv
// Shared types for the double-buffered pointwise-weight group prefetcher.
// Fetch/bank state enums, packed requant param record and width helpers.
package mobilenet_pw_prefetch_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} fetch_st_e;
    typedef enum logic [1:0] {EMPTY, FILLING, FULL} bank_st_e;

    localparam int unsigned DEF_MUL_W   = 16;
    localparam int unsigned DEF_BIAS_W  = 32;
    localparam int unsigned DEF_SHIFT_W = 6;

    typedef struct packed {
        logic [DEF_MUL_W-1:0]   mul;
        logic [DEF_BIAS_W-1:0]  bias;
        logic [DEF_SHIFT_W-1:0] shift;
    } pw_param_t;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned DEF_LANE_W = idx_w(16);
    localparam int unsigned DEF_IDX_W  = idx_w(1024);

endpackage

// File: rtl/mobilenet_pw_group_prefetch_bank.sv
// One prefetch bank: GROUP_OC x MAX_IN_C weight RAM plus per-lane params.
// Single write port, registered read port; zero-filled lanes read back as 0.
module pw_prefetch_bank
    import mobilenet_pw_prefetch_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned PARAM_W  = 54,
    parameter int unsigned GROUP_OC = 16,
    parameter int unsigned MAX_IN_C = 1024,
    parameter int unsigned LANE_W   = idx_w(GROUP_OC),
    parameter int unsigned IDX_W    = idx_w(MAX_IN_C)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               w_we_i,
    input  logic               p_we_i,
    input  logic               zero_i,
    input  logic [LANE_W-1:0]  wr_lane_i,
    input  logic [IDX_W-1:0]   wr_ic_i,
    input  logic [DATA_W-1:0]  wr_w_i,
    input  logic [PARAM_W-1:0] wr_p_i,
    input  logic [LANE_W-1:0]  rd_lane_i,
    input  logic [IDX_W-1:0]   rd_ic_i,
    output logic [DATA_W-1:0]  rd_w_o,
    output logic [PARAM_W-1:0] rd_p_o
);
    localparam int unsigned DEPTH = GROUP_OC * MAX_IN_C;
    localparam int unsigned AW    = idx_w(DEPTH);

    logic [DATA_W-1:0]   w_mem [DEPTH];
    logic [PARAM_W-1:0]  p_q   [GROUP_OC];
    logic [GROUP_OC-1:0] zf_q;
    logic [DATA_W-1:0]   rd_w_q;
    logic [PARAM_W-1:0]  rd_p_q;
    logic [AW-1:0]       wa;
    logic [AW-1:0]       ra;

    assign wa = AW'(wr_lane_i) * AW'(MAX_IN_C) + AW'(wr_ic_i);
    assign ra = AW'(rd_lane_i) * AW'(MAX_IN_C) + AW'(rd_ic_i);

    always_ff @(posedge clk) begin
        if (w_we_i) begin
            w_mem[wa] <= wr_w_i;
        end
        if (p_we_i) begin
            p_q[wr_lane_i]  <= wr_p_i;
            zf_q[wr_lane_i] <= zero_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_w_q <= '0;
            rd_p_q <= '0;
        end else begin
            rd_w_q <= zf_q[rd_lane_i] ? '0 : w_mem[ra];
            rd_p_q <= p_q[rd_lane_i];
        end
    end

    assign rd_w_o = rd_w_q;
    assign rd_p_o = rd_p_q;

endmodule

// File: rtl/mobilenet_pw_group_prefetch.sv
// Double-buffered PW weight group prefetcher with a 2-entry bank FIFO.
// Optional stall counter enabled by PW_PREFETCH_PERF_EN.
module mobilenet_pw_group_prefetch
    import mobilenet_pw_prefetch_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned MUL_W    = 16,
    parameter int unsigned BIAS_W   = 32,
    parameter int unsigned SHIFT_W  = 6,
    parameter int unsigned DIM_W    = 16,
    parameter int unsigned GROUP_OC = 16,
    parameter int unsigned MAX_IN_C = 1024,
    parameter int unsigned MEM_LAT  = 2,
    parameter int unsigned ADDR_W   = 20
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [DIM_W-1:0]                layer_in_c,
    input  logic [DIM_W-1:0]                layer_out_c,
    input  logic [ADDR_W-1:0]               layer_w_base,
    input  logic [ADDR_W-1:0]               layer_p_base,
    input  logic                            req_valid,
    input  logic [DIM_W-1:0]                req_group,
    output logic                            req_ready,
    output logic                            mem_rd_en,
    output logic [ADDR_W-1:0]               mem_w_addr,
    output logic [ADDR_W-1:0]               mem_p_addr,
    input  logic [DATA_W-1:0]               mem_w_data,
    input  logic [MUL_W+BIAS_W+SHIFT_W-1:0] mem_p_data,
    output logic                            cons_ready,
    output logic [DIM_W-1:0]                cons_group,
    input  logic                            cons_release,
    input  logic [DIM_W-1:0]                pw_oc_lane,
    input  logic [DIM_W-1:0]                pw_in_ch_idx,
    output logic [DATA_W-1:0]               pw_weight,
    output logic [MUL_W-1:0]                pw_mul,
    output logic [BIAS_W-1:0]               pw_bias,
    output logic [SHIFT_W-1:0]              pw_shift,
    output logic [31:0]                     stall_cycles
);
    localparam int unsigned PARAM_W = MUL_W + BIAS_W + SHIFT_W;
    localparam int unsigned LANE_W  = idx_w(GROUP_OC);
    localparam int unsigned IDX_W   = idx_w(MAX_IN_C);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(GROUP_OC - 1);

    fetch_st_e         st_q, st_d;
    logic [LANE_W-1:0] oc_q, oc_d;
    logic [DIM_W-1:0]  ic_q, ic_d;
    logic [DIM_W-1:0]  grp_q, grp_d;
    bank_st_e          bst_q [2];
    logic [DIM_W-1:0]  tag_q [2];
    logic              fill_ptr_q, cons_ptr_q;
    logic [1:0]        cnt_q;
    logic [MEM_LAT-1:0] v_q, z_q;
    logic [LANE_W-1:0] tl_q [MEM_LAT];
    logic [IDX_W-1:0]  ti_q [MEM_LAT];
    logic              oob_q, sel_q;

    logic accept, fill_done, rel, lane_oob, lane_end, issue, rd_oob;
    logic wr_v, wr_z, w_we, p_we;
    logic [ADDR_W-1:0]  gidx;
    logic [DATA_W-1:0]  wr_w;
    logic [PARAM_W-1:0] wr_p;
    logic [DATA_W-1:0]  rd_w [2];
    logic [PARAM_W-1:0] rd_p [2];
    logic [PARAM_W-1:0] p_out;

    assign req_ready  = !rst && st_q == IDLE && cnt_q != 2'd2;
    assign accept     = req_valid && req_ready;
    assign cons_ready = bst_q[cons_ptr_q] == FULL;
    assign cons_group = tag_q[cons_ptr_q];
    assign rel        = cons_release && cons_ready;

    // Lanes past layer_out_c issue no reads and retire in a single cycle.
    assign gidx       = ADDR_W'(grp_q) * ADDR_W'(GROUP_OC) + ADDR_W'(oc_q);
    assign lane_oob   = gidx >= ADDR_W'(layer_out_c);
    assign lane_end   = lane_oob || ic_q == layer_in_c - 1'b1;
    assign issue      = st_q == ISSUE;
    assign mem_rd_en  = issue && !lane_oob;
    assign mem_w_addr = layer_w_base + gidx * ADDR_W'(layer_in_c) + ADDR_W'(ic_q);
    assign mem_p_addr = layer_p_base + gidx;

    always_comb begin
        st_d      = st_q;
        oc_d      = oc_q;
        ic_d      = ic_q;
        grp_d     = grp_q;
        fill_done = 1'b0;
        unique case (st_q)
            IDLE: begin
                if (accept) begin
                    st_d  = ISSUE;
                    oc_d  = '0;
                    ic_d  = '0;
                    grp_d = req_group;
                end
            end
            ISSUE: begin
                if (oc_q == LAST_LANE && lane_end) st_d = DRAIN;
                if (lane_end) begin
                    ic_d = '0;
                    oc_d = oc_q + 1'b1;
                end else begin
                    ic_d = ic_q + 1'b1;
                end
            end
            DRAIN: begin
                if (v_q == '0) begin
                    st_d      = IDLE;
                    fill_done = 1'b1;
                end
            end
            default: st_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q  <= IDLE;
            oc_q  <= '0;
            ic_q  <= '0;
            grp_q <= '0;
        end else begin
            st_q  <= st_d;
            oc_q  <= oc_d;
            ic_q  <= ic_d;
            grp_q <= grp_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
            z_q <= '0;
        end else begin
            v_q <= MEM_LAT'({v_q, issue});
            z_q <= MEM_LAT'({z_q, lane_oob});
        end
    end

    always_ff @(posedge clk) begin
        tl_q[0] <= oc_q;
        ti_q[0] <= IDX_W'(ic_q);
        for (int i = 1; i < MEM_LAT; i++) begin
            tl_q[i] <= tl_q[i-1];
            ti_q[i] <= ti_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                bst_q[b] <= EMPTY;
                tag_q[b] <= '0;
            end
            fill_ptr_q <= 1'b0;
            cons_ptr_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            if (accept) begin
                bst_q[fill_ptr_q] <= FILLING;
                tag_q[fill_ptr_q] <= req_group;
            end
            if (fill_done) begin
                bst_q[fill_ptr_q] <= FULL;
                fill_ptr_q        <= ~fill_ptr_q;
            end
            if (rel) begin
                bst_q[cons_ptr_q] <= EMPTY;
                cons_ptr_q        <= ~cons_ptr_q;
            end
            cnt_q <= cnt_q + {1'b0, fill_done} - {1'b0, rel};
        end
    end

    assign wr_v = v_q[MEM_LAT-1];
    assign wr_z = z_q[MEM_LAT-1];
    assign w_we = wr_v && !wr_z;
    assign p_we = wr_v && ti_q[MEM_LAT-1] == '0;
    assign wr_w = wr_z ? '0 : mem_w_data;
    assign wr_p = wr_z ? '0 : mem_p_data;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        pw_prefetch_bank #(
            .DATA_W   (DATA_W),
            .PARAM_W  (PARAM_W),
            .GROUP_OC (GROUP_OC),
            .MAX_IN_C (MAX_IN_C),
            .LANE_W   (LANE_W),
            .IDX_W    (IDX_W)
        ) u_bank (
            .clk       (clk),
            .rst       (rst),
            .w_we_i    (w_we && fill_ptr_q == 1'(b)),
            .p_we_i    (p_we && fill_ptr_q == 1'(b)),
            .zero_i    (wr_z),
            .wr_lane_i (tl_q[MEM_LAT-1]),
            .wr_ic_i   (ti_q[MEM_LAT-1]),
            .wr_w_i    (wr_w),
            .wr_p_i    (wr_p),
            .rd_lane_i (LANE_W'(pw_oc_lane)),
            .rd_ic_i   (IDX_W'(pw_in_ch_idx)),
            .rd_w_o    (rd_w[b]),
            .rd_p_o    (rd_p[b])
        );
    end

    assign rd_oob = 32'(pw_oc_lane) >= GROUP_OC
                 || 32'(pw_in_ch_idx) >= 32'(layer_in_c)
                 || 32'(pw_in_ch_idx) >= MAX_IN_C;

    always_ff @(posedge clk) begin
        if (rst) begin
            oob_q <= 1'b1;
            sel_q <= 1'b0;
        end else begin
            oob_q <= rd_oob;
            sel_q <= cons_ptr_q;
        end
    end

    assign p_out     = oob_q ? '0 : rd_p[sel_q];
    assign pw_weight = oob_q ? '0 : rd_w[sel_q];
    assign pw_mul    = p_out[PARAM_W-1 -: MUL_W];
    assign pw_bias   = p_out[SHIFT_W +: BIAS_W];
    assign pw_shift  = p_out[SHIFT_W-1:0];

`ifdef PW_PREFETCH_PERF_EN
    logic [31:0] stall_q;
    logic        starved;

    assign starved = !cons_ready && (cnt_q == '0 || st_q != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if (starved && stall_q != '1) begin
            stall_q <= stall_q + 1'b1;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_mobilenet_pw_group_prefetch.sv
// Directed bench for mobilenet_pw_group_prefetch with a fixed-latency memory model.
// Address-hashed memory contents give every expected word independently of the DUT.
module tb_mobilenet_pw_group_prefetch;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] layer_in_c, layer_out_c;
    logic [19:0] layer_w_base, layer_p_base;
    logic        req_valid;
    logic [15:0] req_group;
    logic        req_ready;
    logic        mem_rd_en;
    logic [19:0] mem_w_addr, mem_p_addr;
    logic [7:0]  mem_w_data;
    logic [53:0] mem_p_data;
    logic        cons_ready;
    logic [15:0] cons_group;
    logic        cons_release;
    logic [15:0] pw_oc_lane, pw_in_ch_idx;
    logic [7:0]  pw_weight;
    logic [15:0] pw_mul;
    logic [31:0] pw_bias;
    logic [5:0]  pw_shift;
    logic [31:0] stall_cycles;

    int n_pass = 0;
    int n_tot  = 0;
    int cin, cout;
    logic [19:0] wb, pb;

    mobilenet_pw_group_prefetch #(.MEM_LAT(LAT)) dut (
        .clk          (clk),
        .rst          (rst),
        .layer_in_c   (layer_in_c),
        .layer_out_c  (layer_out_c),
        .layer_w_base (layer_w_base),
        .layer_p_base (layer_p_base),
        .req_valid    (req_valid),
        .req_group    (req_group),
        .req_ready    (req_ready),
        .mem_rd_en    (mem_rd_en),
        .mem_w_addr   (mem_w_addr),
        .mem_p_addr   (mem_p_addr),
        .mem_w_data   (mem_w_data),
        .mem_p_data   (mem_p_data),
        .cons_ready   (cons_ready),
        .cons_group   (cons_group),
        .cons_release (cons_release),
        .pw_oc_lane   (pw_oc_lane),
        .pw_in_ch_idx (pw_in_ch_idx),
        .pw_weight    (pw_weight),
        .pw_mul       (pw_mul),
        .pw_bias      (pw_bias),
        .pw_shift     (pw_shift),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] wfun(input logic [19:0] a);
        return 8'(32'(a) * 7 + 32'(a >> 8) + 3);
    endfunction

    function automatic logic [53:0] pfun(input logic [19:0] a);
        logic [15:0] m;
        logic [31:0] b;
        logic [5:0]  s;
        m = 16'(a) ^ 16'hA5C3;
        b = 32'(a) * 32'h9E3779B1 + 32'd1;
        s = 6'(a + (a >> 6));
        return {m, b, s};
    endfunction

    // Fixed-latency backing store; keeps delivering even across DUT reset.
    logic        en_p [LAT];
    logic [19:0] wa_p [LAT];
    logic [19:0] pa_p [LAT];

    always @(posedge clk) begin
        en_p[0] <= mem_rd_en;
        wa_p[0] <= mem_w_addr;
        pa_p[0] <= mem_p_addr;
        for (int i = 1; i < LAT; i++) begin
            en_p[i] <= en_p[i-1];
            wa_p[i] <= wa_p[i-1];
            pa_p[i] <= pa_p[i-1];
        end
    end

    assign mem_w_data = en_p[LAT-1] ? wfun(wa_p[LAT-1]) : 8'hEE;
    assign mem_p_data = en_p[LAT-1] ? pfun(pa_p[LAT-1]) : {54{1'b1}};

    function automatic logic [7:0] exp_w(input int grp, input int lane, input int ic);
        int g;
        g = grp * 16 + lane;
        if (lane >= 16 || ic >= cin || g >= cout) return 8'd0;
        return wfun(20'(32'(wb) + g * cin + ic));
    endfunction

    function automatic logic [53:0] exp_p(input int grp, input int lane, input int ic);
        int g;
        g = grp * 16 + lane;
        if (lane >= 16 || ic >= cin || g >= cout) return 54'd0;
        return pfun(20'(32'(pb) + g));
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic setup(input int ic, input int oc, input logic [19:0] w, input logic [19:0] p);
        cin = ic; cout = oc; wb = w; pb = p;
        layer_in_c = 16'(ic);
        layer_out_c = 16'(oc);
        layer_w_base = w;
        layer_p_base = p;
    endtask

    task automatic request(input int grp);
        int k;
        k = 0;
        @(negedge clk);
        while (!req_ready && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (!req_ready) chk("req_wait", 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_group = 16'(grp);
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_load(output int edges, output int reads);
        edges = -1;
        reads = 0;
        for (int k = 1; k <= 3000; k++) begin
            @(negedge clk);
            if (mem_rd_en) reads++;
            if (cons_ready) begin
                edges = k - 1;
                break;
            end
        end
    endtask

    task automatic rd(input int lane, input int ic, output logic [7:0] w, output logic [53:0] p);
        @(negedge clk);
        pw_oc_lane = 16'(lane);
        pw_in_ch_idx = 16'(ic);
        @(negedge clk);
        w = pw_weight;
        p = {pw_mul, pw_bias, pw_shift};
    endtask

    task automatic chk_rd(input string nm, input int grp, input int lane, input int ic);
        logic [7:0]  w;
        logic [53:0] p;
        rd(lane, ic, w, p);
        chk({nm, "_w"}, 64'(w), 64'(exp_w(grp, lane, ic)));
        chk({nm, "_p"}, 64'(p), 64'(exp_p(grp, lane, ic)));
    endtask

    task automatic release_head();
        @(negedge clk);
        cons_release = 1'b1;
        @(negedge clk);
        cons_release = 1'b0;
    endtask

    typedef struct {
        int          lane;
        int          ic;
        logic [7:0]  w;
        logic [53:0] p;
    } vec_t;

    vec_t tv [8];

    initial begin
        int edges, reads, s0, s1, exp_stall;
        logic [7:0]  w;
        logic [53:0] p;

        rst = 1'b1;
        req_valid = 1'b0;
        req_group = '0;
        cons_release = 1'b0;
        pw_oc_lane = '0;
        pw_in_ch_idx = '0;
        setup(32, 64, 20'h01000, 20'h00200);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rd_en", 64'(mem_rd_en), 64'd0);
        chk("rst_stall", 64'(stall_cycles), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_req_ready", 64'(req_ready), 64'd1);
        chk("post_cons_ready", 64'(cons_ready), 64'd0);
        chk("post_cons_group", 64'(cons_group), 64'd0);
        chk("post_pw", 64'({pw_weight, pw_mul, pw_bias, pw_shift}), 64'd0);

`ifdef PW_PREFETCH_PERF_EN
        exp_stall = 20;
`else
        exp_stall = 0;
`endif
        s0 = int'(stall_cycles);
        repeat (20) @(negedge clk);
        s1 = int'(stall_cycles);
        chk("stall_20_idle", 64'(s1 - s0), 64'(exp_stall));

        // Single full group
        request(0);
        wait_load(edges, reads);
        chk("single_latency", 64'(edges), 64'(512 + LAT + 1));
        chk("single_reads", 64'(reads), 64'd512);
        chk("single_group", 64'(cons_group), 64'd0);

        tv[0] = '{3, 5, wfun(20'h01000 + 20'(3 * 32 + 5)), pfun(20'h00200 + 20'd3)};
        tv[1] = '{0, 0, exp_w(0, 0, 0), exp_p(0, 0, 0)};
        tv[2] = '{15, 31, exp_w(0, 15, 31), exp_p(0, 15, 31)};
        tv[3] = '{7, 16, exp_w(0, 7, 16), exp_p(0, 7, 16)};
        tv[4] = '{3, 32, 8'd0, 54'd0};
        tv[5] = '{16, 0, 8'd0, 54'd0};
        tv[6] = '{1, 31, exp_w(0, 1, 31), exp_p(0, 1, 31)};
        tv[7] = '{10, 0, exp_w(0, 10, 0), exp_p(0, 10, 0)};
        for (int i = 0; i < 8; i++) begin
            rd(tv[i].lane, tv[i].ic, w, p);
            chk($sformatf("tbl%0d_w", i), 64'(w), 64'(tv[i].w));
            chk($sformatf("tbl%0d_p", i), 64'(p), 64'(tv[i].p));
        end
        release_head();
        chk("single_released", 64'(cons_ready), 64'd0);

        // Ping-pong: two groups back to back
        setup(4, 64, 20'h04000, 20'h00400);
        request(0);
        request(1);
        repeat (70) @(negedge clk);
        chk("pp_req_ready_full", 64'(req_ready), 64'd0);
        chk("pp_head_ready", 64'(cons_ready), 64'd1);
        chk("pp_head_group0", 64'(cons_group), 64'd0);
        chk_rd("pp_g0", 0, 2, 1);
        release_head();
        chk("pp_head_group1", 64'(cons_group), 64'd1);
        chk("pp_head_ready1", 64'(cons_ready), 64'd1);
        chk("pp_req_ready_free", 64'(req_ready), 64'd1);
        chk_rd("pp_g1", 1, 2, 1);
        release_head();
        chk("pp_empty", 64'(cons_ready), 64'd0);

        // Partial last group: lanes 8..15 zero-filled
        setup(4, 40, 20'h08000, 20'h00800);
        request(2);
        wait_load(edges, reads);
        chk("part_latency", 64'(edges), 64'(8 * 4 + 8 + LAT + 1));
        chk("part_reads", 64'(reads), 64'd32);
        chk_rd("part_l7", 2, 7, 3);
        chk_rd("part_l9", 2, 9, 1);
        chk_rd("part_l8", 2, 8, 0);
        chk_rd("part_l15", 2, 15, 3);
        release_head();

        // Release coincides with fill completion
        setup(4, 64, 20'h0C000, 20'h00C00);
        request(3);
        wait_load(edges, reads);
        chk("sim_first_latency", 64'(edges), 64'(64 + LAT + 1));
        request(4);
        repeat (64 + LAT) @(posedge clk);
        @(negedge clk);
        chk("sim_before_group", 64'(cons_group), 64'd3);
        cons_release = 1'b1;
        @(negedge clk);
        cons_release = 1'b0;
        chk("sim_after_group", 64'(cons_group), 64'd4);
        chk("sim_after_ready", 64'(cons_ready), 64'd1);
        chk("sim_req_ready", 64'(req_ready), 64'd1);
        chk_rd("sim_g4", 4, 1, 2);
        release_head();
        chk("sim_drained", 64'(cons_ready), 64'd0);

        // Reset in the middle of ISSUE
        setup(32, 64, 20'h01000, 20'h00200);
        pw_oc_lane = 16'd3;
        pw_in_ch_idx = 16'd5;
        request(0);
        reads = 0;
        for (int k = 0; k < 3000 && reads < 100; k++) begin
            @(negedge clk);
            if (mem_rd_en) reads++;
        end
        chk("mid_reads", 64'(reads), 64'd100);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_req_ready", 64'(req_ready), 64'd0);
        chk("mid_rst_rd_en", 64'(mem_rd_en), 64'd0);
        chk("mid_rst_cons", 64'({cons_ready, cons_group}), 64'd0);
        chk("mid_rst_pw", 64'({pw_weight, pw_mul, pw_bias, pw_shift}), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_post_req_ready", 64'(req_ready), 64'd1);
        chk("mid_post_rd_en", 64'(mem_rd_en), 64'd0);
        setup(4, 64, 20'h03000, 20'h00300);
        request(1);
        wait_load(edges, reads);
        chk("mid_new_latency", 64'(edges), 64'(64 + LAT + 1));
        chk("mid_new_reads", 64'(reads), 64'd64);
        chk("mid_new_group", 64'(cons_group), 64'd1);
        chk_rd("mid_new_l0", 1, 0, 0);
        chk_rd("mid_new_l15", 1, 15, 3);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
